frame_renderer: RTL and testbench
=================================

// Module: frame_renderer
// PURPOSE
//   Downstream consumer of the game datapath.
//   On each start pulse it walks the 160x120 bullet grid, then the user ship and enemy sprites.
//   It emits one pixel per clock to the VGA adapter write port (x, y, colour, plot).
//   It sits between the datapath outputs and the vga_adapter instance; the top-level FSM raises start once per frame tick.
// PARAMETERS
//   SCREEN_W     160   grid/screen width in pixels
//   SCREEN_H     120   grid/screen height in pixels
//   SHIP_W       8     sprite width (user and enemy)
//   SHIP_H       4     sprite height
//   USER_Y       112   top row of user ship sprite
//   ENEMY_Y      4     top row of enemy sprite
//   BULLET_COL   3'b111  colour of a set grid bit; clear bit -> 3'b000
//   USER_COL     3'b010  user ship colour
//   ENEMY_COL    3'b100  enemy colour
// PORTS
//   clk      in   1                    50 MHz system clock
//   reset    in   1                    asynchronous, active-low (KEY[0])
//   start    in   1                    1-cycle request to render one frame
//   grid     in   SCREEN_W*SCREEN_H    bullet bitmap, bit index = y*SCREEN_W + x
//   user_x   in   8                    left column of user ship
//   enemy_x  in   8                    left column of enemy
//   x        out  8                    pixel column to VGA adapter
//   y        out  7                    pixel row to VGA adapter
//   colour   out  3                    pixel colour to VGA adapter
//   plot     out  1                    write enable to VGA adapter
//   busy     out  1                    high from accepted start until done
//   done     out  1                    1-cycle pulse at end of frame
// BEHAVIOUR
//   - Reset (any time, async): state=IDLE; x, y, colour, plot, busy, done = 0; counters = 0.
//   - All outputs are registered. A pixel appears on x/y/colour with plot=1 on the cycle after its counter value.
//   - FSM: IDLE -> LATCH -> SCAN -> USER -> ENEMY -> DONE -> IDLE.
//   - IDLE: wait for start. start while busy is ignored, never queued.
//   - LATCH (1 cycle): snapshot user_x and enemy_x into internal registers.
//     The grid is NOT snapshotted; it is sampled live, one bit per SCAN cycle.
//   - SCAN: cx runs 0..SCREEN_W-1 (inner loop); cy runs 0..SCREEN_H-1 (outer loop).
//     Every cycle: plot=1; colour = grid[cy*W+cx] ? BULLET_COL : 0.
//     Duration is exactly SCREEN_W*SCREEN_H = 19200 cycles.
//   - USER: sx runs 0..SHIP_W-1 (inner); sy runs 0..SHIP_H-1 (outer).
//     Pixel = (user_x_l+sx, USER_Y+sy), colour USER_COL.
//   - ENEMY: same walk, at (enemy_x_l+sx, ENEMY_Y+sy), colour ENEMY_COL.
//     Enemy is drawn last, so it overdraws the ship and bullets on overlap.
//   - Clipping: compute sprite column in 9 bits. If >= SCREEN_W, plot=0 for that pixel.
//     The counter still advances, so sprite phase length is fixed at SHIP_W*SHIP_H.
//   - DONE (1 cycle): done=1, plot=0, busy drops to 0 the same cycle.
//   - busy=1 from LATCH through ENEMY inclusive.
//   - Total start->done latency = 1 + 19200 + 2*32 + 1 = 19266 cycles, with default parameters.
//   - plot=0 in IDLE, LATCH and DONE.
//   - x/y hold their last value when plot=0.
//   - Counters wrap to 0 on phase exit, so no stale value leaks into the next phase.
// STRUCTURE
//   - Shared package starflux_pkg holds:
//     SCREEN_W/SCREEN_H and the colour constants (shared with the datapath, shifter_grid and the top level);
//     the renderer state encoding localparams (IDLE, LATCH, SCAN, USER, ENEMY, DONE).
//   - One sub-module, xy_counter2d (params W, H).
//     Inputs: en, clr. Outputs: cx, cy, last (high on the final count).
//     Instantiated once for SCAN (W=SCREEN_W, H=SCREEN_H).
//     Instantiated once, shared, for both sprite phases (W=SHIP_W, H=SHIP_H), cleared on each phase entry.
// TESTING
//   1 Reset: hold reset=0 mid-SCAN -> plot, busy, done = 0 immediately; release -> IDLE; no pixel until next start.
//   2 Empty grid, user_x=10, enemy_x=50, pulse start:
//     -> 19200 plots with colour 0; then 32 plots x=10..17, y=112..115, col 010;
//     -> then 32 plots x=50..57, y=4..7, col 100; done at cycle 19266.
//   3 Grid bit 5*160+7 set -> exactly one SCAN pixel (x=7, y=5) has colour 111; all others 0.
//   4 user_x=156 -> sprite columns 156..159 plotted; columns 160..163 have plot=0; done cycle unchanged.
//   5 start pulsed again at cycle 100 of a frame -> ignored; exactly one done pulse; user_x changed mid-frame -> sprite uses latched value.
//   6 enemy_x=user_x and the sprites' rows overlap (set ENEMY_Y=USER_Y) -> final writes to overlapped pixels carry ENEMY_COL.

Source files
------------

// File: rtl/starflux_pkg.sv
// Shared screen geometry, colour constants and renderer state encoding
// used by the datapath, shifter_grid, frame_renderer and the top level.
package starflux_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] BLANK_COL  = 3'b000;
    localparam logic [2:0] BULLET_COL = 3'b111;
    localparam logic [2:0] USER_COL   = 3'b010;
    localparam logic [2:0] ENEMY_COL  = 3'b100;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SCAN,
        USER,
        ENEMY,
        DONE
    } render_state_e;

endpackage

// File: rtl/xy_counter2d.sv
// Two-dimensional raster counter: cx is the inner loop, cy the outer loop.
// Wraps both coordinates to zero after the final count; clr wins over en.
module xy_counter2d #(
    parameter int W = 8,
    parameter int H = 4,
    localparam int XW = (W > 1) ? $clog2(W) : 1,
    localparam int YW = (H > 1) ? $clog2(H) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          clr_i,
    output logic [XW-1:0] cx_o,
    output logic [YW-1:0] cy_o,
    output logic          last_o
);

    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;
    logic          last_x, last_y;

    assign last_x = (cx_q == XW'(W - 1));
    assign last_y = (cy_q == YW'(H - 1));

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (clr_i) begin
            cx_d = '0;
            cy_d = '0;
        end else if (en_i) begin
            if (last_x) begin
                cx_d = '0;
                cy_d = last_y ? '0 : cy_q + 1'b1;
            end else begin
                cx_d = cx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    assign cx_o   = cx_q;
    assign cy_o   = cy_q;
    assign last_o = last_x & last_y;

endmodule

// File: rtl/frame_renderer.sv
// Walks the bullet grid, then the user ship and enemy sprites, emitting one
// registered pixel per clock to the VGA adapter write port.
module frame_renderer
    import starflux_pkg::*;
#(
    parameter int SHIP_W  = 8,
    parameter int SHIP_H  = 4,
    parameter int USER_Y  = 112,
    parameter int ENEMY_Y = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic [SCREEN_W*SCREEN_H-1:0] grid_i,
    input  logic [7:0]                   user_x_i,
    input  logic [7:0]                   enemy_x_i,
    output logic [7:0]                   x_o,
    output logic [6:0]                   y_o,
    output logic [2:0]                   colour_o,
    output logic                         plot_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int GRID_N = SCREEN_W * SCREEN_H;
    localparam int IDX_W  = $clog2(GRID_N);
    localparam int CX_W   = $clog2(SCREEN_W);
    localparam int CY_W   = $clog2(SCREEN_H);
    localparam int SX_W   = (SHIP_W > 1) ? $clog2(SHIP_W) : 1;
    localparam int SY_W   = (SHIP_H > 1) ? $clog2(SHIP_H) : 1;

    render_state_e state_q, state_d;

    logic [7:0]      user_x_q, enemy_x_q;
    logic            scan_en, scan_clr, scan_last;
    logic            spr_en, spr_clr, spr_last;
    logic [CX_W-1:0] cx;
    logic [CY_W-1:0] cy;
    logic [SX_W-1:0] sx;
    logic [SY_W-1:0] sy;

    logic [IDX_W-1:0] grid_idx;
    logic [8:0]       spr_col9;
    logic [6:0]       spr_row;
    logic [2:0]       spr_colour;

    logic       pix_plot;
    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic [2:0] pix_col;

    logic [7:0] x_q;
    logic [6:0] y_q;
    logic [2:0] colour_q;
    logic       plot_q, busy_q, done_q;

    xy_counter2d #(.W(SCREEN_W), .H(SCREEN_H)) u_scan_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (scan_en),
        .clr_i  (scan_clr),
        .cx_o   (cx),
        .cy_o   (cy),
        .last_o (scan_last)
    );

    // One sprite counter serves both sprite phases; it is cleared on entry to each.
    xy_counter2d #(.W(SHIP_W), .H(SHIP_H)) u_spr_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (spr_en),
        .clr_i  (spr_clr),
        .cx_o   (sx),
        .cy_o   (sy),
        .last_o (spr_last)
    );

    always_comb begin
        state_d  = state_q;
        scan_en  = 1'b0;
        scan_clr = 1'b0;
        spr_en   = 1'b0;
        spr_clr  = 1'b0;
        case (state_q)
            IDLE:  if (start_i) state_d = LATCH;
            LATCH: begin
                scan_clr = 1'b1;
                state_d  = SCAN;
            end
            SCAN: begin
                scan_en = 1'b1;
                if (scan_last) begin
                    spr_clr = 1'b1;
                    state_d = USER;
                end
            end
            USER: begin
                spr_en = 1'b1;
                if (spr_last) begin
                    spr_clr = 1'b1;
                    state_d = ENEMY;
                end
            end
            ENEMY: begin
                spr_en = 1'b1;
                if (spr_last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Sprite positions are frozen for the whole frame; the grid is sampled live.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            user_x_q  <= '0;
            enemy_x_q <= '0;
        end else if (state_q == LATCH) begin
            user_x_q  <= user_x_i;
            enemy_x_q <= enemy_x_i;
        end
    end

    always_comb begin
        grid_idx   = IDX_W'(cy) * IDX_W'(SCREEN_W) + IDX_W'(cx);
        spr_col9   = {1'b0, user_x_q} + 9'(sx);
        spr_row    = 7'(USER_Y) + 7'(sy);
        spr_colour = USER_COL;
        if (state_q == ENEMY) begin
            spr_col9   = {1'b0, enemy_x_q} + 9'(sx);
            spr_row    = 7'(ENEMY_Y) + 7'(sy);
            spr_colour = ENEMY_COL;
        end
    end

    always_comb begin
        pix_plot = 1'b0;
        pix_x    = x_q;
        pix_y    = y_q;
        pix_col  = colour_q;
        case (state_q)
            SCAN: begin
                pix_plot = 1'b1;
                pix_x    = 8'(cx);
                pix_y    = 7'(cy);
                pix_col  = grid_i[grid_idx] ? BULLET_COL : BLANK_COL;
            end
            // Columns past the right edge are suppressed but still consume a cycle.
            USER, ENEMY: begin
                if (spr_col9 < 9'(SCREEN_W)) begin
                    pix_plot = 1'b1;
                    pix_x    = spr_col9[7:0];
                    pix_y    = spr_row;
                    pix_col  = spr_colour;
                end
            end
            default: pix_plot = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            x_q      <= pix_x;
            y_q      <= pix_y;
            colour_q <= pix_col;
            plot_q   <= pix_plot;
            busy_q   <= (state_q == LATCH) || (state_q == SCAN) ||
                        (state_q == USER)  || (state_q == ENEMY);
            done_q   <= (state_q == DONE);
        end
    end

    assign x_o      = x_q;
    assign y_o      = y_q;
    assign colour_o = colour_q;
    assign plot_o   = plot_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_frame_renderer.sv
// Scoreboard bench for frame_renderer: a default instance plus one with the
// enemy placed on the user ship's rows to exercise sprite overdraw.
module tb_frame_renderer;
    import starflux_pkg::*;

    localparam int GRID_N  = SCREEN_W * SCREEN_H;
    localparam int LATENCY = 1 + GRID_N + 2 * 32 + 1;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [GRID_N-1:0] grid;
    logic [7:0]        user_x0, enemy_x0, user_x1, enemy_x1;
    logic [7:0]        x0, x1;
    logic [6:0]        y0, y1;
    logic [2:0]        col0, col1;
    logic              plot0, plot1, busy0, busy1, done0, done1;

    int assertCount = 0;
    int failCount   = 0;
    int doneCnt0, doneCnt1, plotCnt0, bulletCnt0;

    logic [17:0] q0[$];
    logic [17:0] q1[$];

    frame_renderer dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .grid_i(grid),
        .user_x_i(user_x0), .enemy_x_i(enemy_x0),
        .x_o(x0), .y_o(y0), .colour_o(col0),
        .plot_o(plot0), .busy_o(busy0), .done_o(done0)
    );

    frame_renderer #(.ENEMY_Y(112)) dutOverlap (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .grid_i(grid),
        .user_x_i(user_x1), .enemy_x_i(enemy_x1),
        .x_o(x1), .y_o(y1), .colour_o(col1),
        .plot_o(plot1), .busy_o(busy1), .done_o(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    task automatic pushPix(input bit which, input logic [17:0] pix);
        if (which) q1.push_back(pix);
        else       q0.push_back(pix);
    endtask

    // Reference picture for one frame, in plot order, from the values latched at start.
    task automatic pushFrame(input bit which, input logic [7:0] ux,
                             input logic [7:0] ex, input int ey);
        for (int yy = 0; yy < SCREEN_H; yy++)
            for (int xx = 0; xx < SCREEN_W; xx++)
                pushPix(which, {8'(xx), 7'(yy),
                                grid[yy*SCREEN_W+xx] ? 3'b111 : 3'b000});
        for (int sy = 0; sy < 4; sy++)
            for (int sx = 0; sx < 8; sx++)
                if (int'(ux) + sx < SCREEN_W)
                    pushPix(which, {8'(int'(ux) + sx), 7'(112 + sy), 3'b010});
        for (int sy = 0; sy < 4; sy++)
            for (int sx = 0; sx < 8; sx++)
                if (int'(ex) + sx < SCREEN_W)
                    pushPix(which, {8'(int'(ex) + sx), 7'(ey + sy), 3'b100});
    endtask

    task automatic applyStimulus(input logic [7:0] ux0, input logic [7:0] ex0,
                                 input logic [7:0] ux1, input logic [7:0] ex1);
        user_x0  = ux0;
        enemy_x0 = ex0;
        user_x1  = ux1;
        enemy_x1 = ex1;
        doneCnt0 = 0;
        doneCnt1 = 0;
        bulletCnt0 = 0;
        pushFrame(1'b0, ux0, ex0, 4);
        pushFrame(1'b1, ux1, ex1, 112);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for both done pulses; optionally re-pulses start and moves the
    // user ship mid-frame to prove both are ignored until the next frame.
    task automatic runFrame(input string tag, input int glitchAt, input logic [7:0] newUx);
        int cyc = 0;
        int lat0 = 0;
        int lat1 = 0;
        while (cyc < LATENCY + 200 && (lat0 == 0 || lat1 == 0)) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done0 && lat0 == 0) lat0 = cyc;
            if (done1 && lat1 == 0) lat1 = cyc;
            if (cyc == glitchAt) begin
                start   = 1'b1;
                user_x0 = newUx;
            end else begin
                start = 1'b0;
            end
        end
        repeat (20) @(negedge clk);
        checkOutput({tag, "_latency0"}, lat0, LATENCY);
        checkOutput({tag, "_latency1"}, lat1, LATENCY);
        checkOutput({tag, "_doneCount0"}, doneCnt0, 1);
        checkOutput({tag, "_doneCount1"}, doneCnt1, 1);
        checkOutput({tag, "_remaining0"}, q0.size(), 0);
        checkOutput({tag, "_remaining1"}, q1.size(), 0);
        checkOutput({tag, "_busyAfter"}, {busy0, busy1}, 0);
    endtask

    // Scoreboard side: every plotted pixel must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done0) doneCnt0++;
            if (done1) doneCnt1++;
            if (plot0) begin
                plotCnt0++;
                if (col0 == 3'b111) bulletCnt0++;
                if (q0.size() == 0) checkOutput("pix0_unexpected", q0.size(), 1);
                else                checkOutput("pix0", {x0, y0, col0}, q0.pop_front());
            end
            if (plot1) begin
                if (q1.size() == 0) checkOutput("pix1_unexpected", q1.size(), 1);
                else                checkOutput("pix1", {x1, y1, col1}, q1.pop_front());
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        grid     = '0;
        user_x0  = '0;
        enemy_x0 = '0;
        user_x1  = '0;
        enemy_x1 = '0;
        plotCnt0 = 0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", {x0, y0, col0, plot0, busy0, done0}, 0);
        rst_n = 1'b1;

        $display("[TB] asynchronous reset in the middle of a scan");
        applyStimulus(8'd10, 8'd50, 8'd30, 8'd30);
        repeat (500) @(negedge clk);
        checkOutput("midscan_busy", {busy0, busy1, plot0}, 3'b111);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset_outputs", {plot0, busy0, done0, plot1, busy1, done1}, 0);
        q0.delete();
        q1.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        plotCnt0 = 0;
        repeat (50) @(negedge clk);
        checkOutput("post_reset_idle", {busy0, done0, busy1, done1}, 0);
        checkOutput("post_reset_noplot", plotCnt0, 0);

        $display("[TB] frame with one bullet, sprites at 10/50, overlap instance at 30");
        grid[5*SCREEN_W+7] = 1'b1;
        applyStimulus(8'd10, 8'd50, 8'd30, 8'd30);
        runFrame("frameA", 0, 8'd0);
        checkOutput("frameA_bulletPixels", bulletCnt0, 1);

        $display("[TB] clipped user ship, ignored restart and mid-frame user_x change");
        grid = '0;
        applyStimulus(8'd156, 8'd50, 8'd100, 8'd100);
        runFrame("frameB", 100, 8'd20);
        checkOutput("frameB_bulletPixels", bulletCnt0, 0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
